// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, status bit indices and defaults
package uart_pkg;

    // Receiver frame-tracking states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        PARITY   = 3'd3,
        STOP     = 3'd4,
        BRK_WAIT = 3'd5
    } rx_state_e;

    // Bit positions of the receive error flags in the RX status register
    localparam int PARITY_ERR_BIT   = 3;
    localparam int BREAK_ERR_BIT    = 4;
    localparam int STOP_ERR_BIT     = 5;
    localparam int OVERFLOW_ERR_BIT = 6;

    // Oversampling ticks per bit used when a block does not override it
    localparam int DEFAULT_SAMPLE = 16;

endpackage

// File: rtl/uart_rx_core_if.sv
// rtl/uart_rx_core_if.sv - received-frame handshake bundle between receiver and RX FIFO
interface uart_rx_core_if #(
    parameter int DATA_SIZE = 8
);
    logic [DATA_SIZE-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_error;
    logic                 stop_error;
    logic                 break_error;
    logic                 overflow_error;

    // Receiver side: presents frames and flags, observes FIFO space
    modport master (
        output rx_data,
        output rx_valid,
        output parity_error,
        output stop_error,
        output break_error,
        output overflow_error,
        input  rx_ready
    );

    // FIFO side: consumes frames and flags, reports space
    modport slave (
        input  rx_data,
        input  rx_valid,
        input  parity_error,
        input  stop_error,
        input  break_error,
        input  overflow_error,
        output rx_ready
    );
endinterface

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - clk divider producing one-cycle oversampling ticks
module uart_baud_tick #(
    parameter int BAUD_DVSR = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    output logic tick_o
);
    localparam int CW = (BAUD_DVSR > 1) ? $clog2(BAUD_DVSR) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DVSR - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == CNT_LAST);

    // Next count: clear restarts the phase, otherwise wrap at the divisor
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Divider counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - oversampling UART receiver with valid/ready frame holding register
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_SIZE  = 8,
    parameter int SYS_FREQ   = 100000000,
    parameter int BAUD_RATE  = 9600,
    parameter int SAMPLE     = DEFAULT_SAMPLE,
    parameter int BAUD_DVSR  = SYS_FREQ / (SAMPLE * BAUD_RATE),
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           serial_data_in,
    output logic           busy,
    uart_rx_core_if.master rx_if
);
    localparam int S_W = $clog2(SAMPLE);
    localparam int N_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam logic [S_W-1:0] S_HALF = S_W'(SAMPLE / 2 - 1);
    localparam logic [S_W-1:0] S_LAST = S_W'(SAMPLE - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(DATA_SIZE - 1);
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    localparam logic PAR_EN  = (PARITY_EN != 0);

    logic [1:0]           sync_q;
    logic                 rx_s;
    logic                 tick;
    logic                 tick_clr;

    rx_state_e            state_q;
    logic [S_W-1:0]       s_q;
    logic [N_W-1:0]       n_q;
    logic [DATA_SIZE-1:0] shift_q;
    logic                 par_bit_q;
    logic                 par_err_q;
    logic                 busy_q;

    logic [DATA_SIZE:0]   shift_ext;
    logic                 frame_done;
    logic                 frame_break;
    logic                 frame_stop_err;

    logic [DATA_SIZE-1:0] data_q;
    logic                 valid_q;
    logic                 perr_q;
    logic                 serr_q;
    logic                 berr_q;
    logic                 ovf_q;
    logic                 xfer;

    // Two-flop synchroniser; idles high so reset never looks like a start edge
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], serial_data_in};
        end
    end

    assign rx_s = sync_q[1];

    // Restart the tick phase at the falling edge so sampling lands mid-bit
    assign tick_clr = (state_q == IDLE) && !rx_s;

    uart_baud_tick #(
        .BAUD_DVSR(BAUD_DVSR)
    ) u_baud_tick (
        .clk    (clk),
        .reset  (reset),
        .clear_i(tick_clr),
        .tick_o (tick)
    );

    assign shift_ext = {rx_s, shift_q};

    // Stop-bit sample is the completion event; classify the frame on that cycle
    assign frame_done     = (state_q == STOP) && tick && (s_q == S_LAST);
    assign frame_break    = (shift_q == '0) && !(PAR_EN && par_bit_q) && !rx_s;
    assign frame_stop_err = !rx_s && !frame_break;

    // Frame FSM: start validation, LSB-first data shift, parity, stop, break hold
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            s_q       <= '0;
            n_q       <= '0;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
            par_err_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q <= START;
                        s_q     <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (s_q == S_HALF) begin
                            s_q <= '0;
                            if (!rx_s) begin
                                state_q   <= DATA;
                                n_q       <= '0;
                                par_bit_q <= 1'b0;
                                par_err_q <= 1'b0;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            s_q <= s_q + S_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s_q == S_LAST) begin
                            s_q     <= '0;
                            shift_q <= shift_ext[DATA_SIZE:1];
                            if (n_q == N_LAST) begin
                                n_q     <= '0;
                                state_q <= PAR_EN ? PARITY : STOP;
                            end else begin
                                n_q <= n_q + N_W'(1);
                            end
                        end else begin
                            s_q <= s_q + S_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        if (s_q == S_LAST) begin
                            s_q       <= '0;
                            par_bit_q <= rx_s;
                            par_err_q <= (^shift_q) ^ rx_s ^ PAR_ODD;
                            state_q   <= STOP;
                        end else begin
                            s_q <= s_q + S_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (s_q == S_LAST) begin
                            s_q <= '0;
                            if (frame_break) begin
                                state_q <= BRK_WAIT;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            s_q <= s_q + S_W'(1);
                        end
                    end
                end
                BRK_WAIT: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    s_q     <= '0;
                    n_q     <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign xfer = valid_q && rx_if.rx_ready;

    // Holding register: load on completion if empty or draining, else drop and flag overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            serr_q  <= 1'b0;
            berr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            ovf_q <= 1'b0;
            if (frame_done) begin
                if (!valid_q || xfer) begin
                    data_q  <= shift_q;
                    valid_q <= 1'b1;
                    perr_q  <= par_err_q;
                    serr_q  <= frame_stop_err;
                    berr_q  <= frame_break;
                end else begin
                    ovf_q <= 1'b1;
                end
            end else if (xfer) begin
                valid_q <= 1'b0;
                perr_q  <= 1'b0;
                serr_q  <= 1'b0;
                berr_q  <= 1'b0;
            end
        end
    end

    assign rx_if.rx_data        = data_q;
    assign rx_if.rx_valid       = valid_q;
    assign rx_if.parity_error   = perr_q;
    assign rx_if.stop_error     = serr_q;
    assign rx_if.break_error    = berr_q;
    assign rx_if.overflow_error = ovf_q;
    assign busy                 = busy_q;
endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - scoreboard bench for uart_rx_core
module tb_uart_rx_core;
    localparam int DW      = 8;
    localparam int BIT_CYC = 160;
    localparam logic PODD  = 1'b0;

    typedef struct {
        logic [DW-1:0] d;
        logic          pe;
        logic          se;
        logic          be;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic serial_data_in = 1'b1;
    logic busy;

    uart_rx_core_if #(.DATA_SIZE(DW)) rx_bus ();

    uart_rx_core #(
        .DATA_SIZE (DW),
        .SYS_FREQ  (1600000),
        .BAUD_RATE (10000),
        .SAMPLE    (16),
        .PARITY_EN (1),
        .PARITY_ODD(0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .serial_data_in(serial_data_in),
        .busy          (busy),
        .rx_if         (rx_bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   ovf_seen = 0;
    int   last_xfer_cyc = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks = n_checks + 1;
        if (act !== req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pop and compare on every accepted frame, count overflow pulses
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_bus.overflow_error) ovf_seen = ovf_seen + 1;
            if (rx_bus.rx_valid && rx_bus.rx_ready) begin
                last_xfer_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_checks = n_checks + 1;
                    n_fail   = n_fail + 1;
                    $display("FAIL unexpected_frame actual=%0h required=none", rx_bus.rx_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rx_data", 32'(rx_bus.rx_data), 32'(mon_e.d));
                    chk("parity_error", 32'(rx_bus.parity_error), 32'(mon_e.pe));
                    chk("stop_error", 32'(rx_bus.stop_error), 32'(mon_e.se));
                    chk("break_error", 32'(rx_bus.break_error), 32'(mon_e.be));
                end
            end
        end
    end

    task automatic hold(input logic v, input int n);
        serial_data_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 rx_bus.rx_ready = v;
        @(negedge clk);
    endtask

    // Reference model: flags follow from the frame content alone
    task automatic send_frame(input logic [DW-1:0] d, input logic flip, input logic stop, input logic expect_out);
        exp_t e;
        logic p;
        p    = (^d) ^ PODD ^ flip;
        e.d  = d;
        e.pe = ((^d) ^ p ^ PODD) != 1'b0;
        e.be = (d == '0) && !p && !stop;
        e.se = !stop && !e.be;
        if (expect_out) exp_q.push_back(e);
        hold(1'b0, BIT_CYC);
        for (int i = 0; i < DW; i++) hold(d[i], BIT_CYC);
        hold(p, BIT_CYC);
        if (stop) begin
            hold(1'b1, BIT_CYC);
        end else begin
            hold(1'b0, 100);
            hold(1'b1, BIT_CYC - 100);
        end
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_rx_valid"}, 32'(rx_bus.rx_valid), 32'd0);
        chk({tag, "_rx_data"}, 32'(rx_bus.rx_data), 32'd0);
        chk({tag, "_flags"}, 32'({rx_bus.parity_error, rx_bus.stop_error, rx_bus.break_error, rx_bus.overflow_error}), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int lat;
        int k;
        int ovf_base;
        logic [DW-1:0] rd;
        logic rf;
        logic rs;

        rx_bus.rx_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk_idle_outputs("reset");
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        hold(1'b1, 50);

        // Clean frame and its latency from the start edge
        t0 = cyc;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        hold(1'b1, 40);
        wait_drain(400);
        lat = last_xfer_cyc - t0;
        chk("latency_window", 32'((lat >= 1678) && (lat <= 1692)), 32'd1);

        // Parity bit inverted
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        hold(1'b1, 40);
        wait_drain(400);

        // Short low glitch must be rejected
        hold(1'b0, 10);
        chk("glitch_busy_high", 32'(busy), 32'd1);
        hold(1'b0, 20);
        k = 0;
        serial_data_in = 1'b1;
        while (busy && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("glitch_busy_low", 32'(busy), 32'd0);
        hold(1'b1, 200);

        // Break: long low line gives exactly one frame
        exp_q.push_back('{d: 8'h00, pe: 1'b0, se: 1'b0, be: 1'b1});
        hold(1'b0, 3200);
        chk("break_busy_hold", 32'(busy), 32'd1);
        hold(1'b1, 200);
        wait_drain(400);
        chk("break_busy_idle", 32'(busy), 32'd0);

        // Overflow: second frame dropped while the first is held
        ovf_base = ovf_seen;
        set_ready(1'b0);
        send_frame(8'h11, 1'b0, 1'b1, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0);
        hold(1'b1, 50);
        chk("ovf_held_valid", 32'(rx_bus.rx_valid), 32'd1);
        chk("ovf_held_data", 32'(rx_bus.rx_data), 32'h11);
        chk("ovf_pulses", 32'(ovf_seen - ovf_base), 32'd1);
        set_ready(1'b1);
        wait_drain(50);
        hold(1'b1, 2);
        chk("ovf_valid_drop", 32'(rx_bus.rx_valid), 32'd0);

        // Reset mid-frame during data bit 3 of 0x77
        hold(1'b0, BIT_CYC);
        hold(1'b1, BIT_CYC);
        hold(1'b1, BIT_CYC);
        hold(1'b1, BIT_CYC);
        hold(1'b0, 80);
        chk("midframe_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1 begin
            reset = 1'b1;
            serial_data_in = 1'b1;
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_idle_outputs("midreset");
        hold(1'b1, 300);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
        hold(1'b1, 40);
        wait_drain(400);

        // Randomised frames with parity and stop corruption
        for (int i = 0; i < 10; i++) begin
            rd = DW'($urandom);
            if (i == 3) rd = '0;
            rf = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 3) != 0);
            if (i == 3) begin
                rf = 1'b0;
                rs = 1'b0;
            end
            send_frame(rd, rf, rs, 1'b1);
            hold(1'b1, $urandom_range(20, 80));
            wait_drain(400);
        end

        hold(1'b1, 100);
        chk("ovf_total", 32'(ovf_seen), 32'd1);
        chk("final_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
